// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Elastic pipeline register with a one-entry skid buffer,
//               registered upstream ready, synchronous flush and NOP bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
    parameter int unsigned               DATA_W     = 64,
    parameter logic [DATA_W-1:0]         RESET_DATA = 64'h00100000_00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    // The state encoding is the occupancy itself, so count needs no decode.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign count     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Any out_fire this cycle has already completed downstream.
            state_d     = EMPTY;
            main_data_d = RESET_DATA;
            skid_data_d = RESET_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        main_data_d = RESET_DATA;
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        skid_data_d = RESET_DATA;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_data_d = RESET_DATA;
                    skid_data_d = RESET_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_DATA;
            skid_data_q <= RESET_DATA;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg using a reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    localparam int unsigned  C_DATA_W     = 64;
    localparam logic [63:0]  C_RESET_DATA = 64'h00100000_00000000;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [C_DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [C_DATA_W-1:0] out_data;
    logic [1:0]        count;

    int n_checks;
    int n_errors;

    logic [63:0] sb_q[$];

    pipe_skid_reg #(
        .DATA_W     (C_DATA_W),
        .RESET_DATA (C_RESET_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs to the model at the falling edge, then advance the model
    // with the inputs that the next rising edge will see.
    task automatic step();
        logic [63:0] exp_word;
        bit          m_in_fire;
        bit          m_out_fire;
        @(negedge clk);
        check("count",     64'(count),     64'(sb_q.size()));
        check("in_ready",  64'(in_ready),  64'(sb_q.size() != 2));
        check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        if (sb_q.size() == 0) begin
            check("bubble_data", out_data, C_RESET_DATA);
        end else if (!out_ready) begin
            check("held_data", out_data, sb_q[0]);
        end
        if (reset) begin
            sb_q.delete();
        end else begin
            m_in_fire  = in_valid && (sb_q.size() != 2);
            m_out_fire = (sb_q.size() != 0) && out_ready;
            if (m_out_fire) begin
                exp_word = sb_q.pop_front();
                check("out_fire_data", out_data, exp_word);
            end
            if (flush) begin
                sb_q.delete();
            end else if (m_in_fire) begin
                sb_q.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD_BEEF_0000_0001;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with upstream offering data
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        // Streaming 1..4 with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Stall/skid: 10,11,12 with out_ready low from the second cycle
        in_valid = 1'b1;
        in_data  = 64'd10;
        out_ready = 1'b1;
        step();
        in_data   = 64'd11;
        out_ready = 1'b0;
        step();
        in_data = 64'd12;
        step();
        step();
        check("stall_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Flush while FULL with 99 on the input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd20;
        step();
        in_data = 64'd21;
        step();
        in_data = 64'd99;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();

        // Flush coinciding with an out_fire of word 5
        in_valid = 1'b1;
        in_data  = 64'd5;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();

        // Randomised traffic against the reference queue
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 3);
            in_data   = {$urandom, $urandom};
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register that replaces the fixed fetch-to-decode latch between any two CPU pipeline stages. It carries a DATA_W-bit packed payload (e.g. {PCPlus4, Instr}) with a valid/ready handshake. A one-entry skid buffer gives full throughput and a registered ready, with no combinational path from downstream ready to upstream ready. Synchronous flush converts held contents into bubbles. Bubbles always present RESET_DATA, so downstream stages see a NOP.

## Interface
- DATA_W, 64: payload width in bits; legal range 1..256.
- RESET_DATA, {32'h00100000, 32'h00000000}: value driven on out_data whenever out_valid=0; default encodes PCPlus4=0x00100000, Instr=NOP.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; empties the stage
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- flush  in  1  synchronous; discard all held and incoming data (branch taken / PCSrc)
- out_valid  out  1  out_data is a real instruction
- out_ready  in  1  downstream accepts (deasserted = stall)
- out_data  out  DATA_W  payload to next stage; RESET_DATA when out_valid=0
- count  out  2  occupancy, 0..2

## Operation
- Storage:
  - Main register (main_data/main_valid) drives out_data/out_valid.
  - Skid register (skid_data/skid_valid) is never visible at the output.
- Transfer conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- State is encoded by count:
  - EMPTY=0: main_valid=0, skid_valid=0.
  - ONE=1: main_valid=1, skid_valid=0.
  - FULL=2: both valid.
- EMPTY:
  - in_fire -> main<=in_data, ONE.
  - Else stay EMPTY.
- ONE:
  - in_fire & out_fire -> main<=in_data, stay ONE.
  - in_fire & !out_fire -> skid<=in_data, FULL.
  - !in_fire & out_fire -> main_data<=RESET_DATA, EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready=0, so no in_fire is possible.
  - out_fire -> main<=skid_data, skid cleared, ONE.
  - Else hold.
- in_ready = (count != 2), taken from registered state only.
- flush (priority over in_fire/out_fire):
  - Next cycle count=0, out_valid=0, out_data=RESET_DATA.
  - in_data offered in the flush cycle is dropped, even if in_ready=1.
  - An out_fire in the flush cycle still completes; downstream owns that word.
- reset (priority over everything): same end state as flush; skid_data<=RESET_DATA.
- Data ordering is strictly FIFO; no word is duplicated or lost except by flush/reset.
- count and the state fields are always mutually consistent.
- The illegal encoding count=3 never occurs.

## Timing
- Reset values of outputs:
  - in_ready=1, out_valid=0, out_data=RESET_DATA, count=0.
- Latency: in_fire in cycle N -> out_valid=1 and out_data=in_data in cycle N+1.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall behaviour:
  - out_ready low for k≥2 cycles under continuous input: exactly one extra word is absorbed.
  - in_ready drops in the cycle after the second word is accepted.
- Stall release: in_ready returns to 1 one cycle after the first out_fire from FULL.
- All outputs change only on rising clk edges; no output depends combinationally on any input.
- Reset or flush asserted mid-stall: takes effect at the next edge regardless of state.

## Test plan
- **Reset:** assert reset 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=64'h00100000_00000000, count=0 throughout and on the first cycle after release.
- **Streaming:** out_ready=1, feed words 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 on cycles N+1..N+4, count stays 1, in_ready stays 1.
- **Stall/skid:** feed 10,11,12 with out_ready=0 from the second cycle ->
  - 10 held at the output, 11 in skid, count=2, in_ready=0, 12 not accepted.
  - Raise out_ready -> outputs 10,11, then 12 after resubmission; nothing lost or duplicated.
- **Flush while FULL:** count=2, assert flush with in_valid=1, in_data=99 -> next cycle count=0, out_valid=0, out_data=RESET_DATA, and 99 never appears.
- **Flush with simultaneous out_fire:** out_valid=1, out_data=5, out_ready=1, flush=1 -> consumer captures 5 that cycle, then the stage is empty.
- **Randomised check:** random in_valid/out_ready/flush over 10k cycles against a reference queue model -> in-order, loss-free except flushed words; count never exceeds 2; out_data==RESET_DATA whenever out_valid=0.
